// File: rtl/uart_tx_feeder.sv
// Byte FIFO ahead of the UART transmitter: issues one pi_flag pulse per byte,
// spaced so that a new frame never starts before the previous stop bit has finished.
module uart_tx_feeder #(
   parameter int unsigned UART_BPS   = 'd9600,
   parameter int unsigned CLK_FREQ   = 'd50_000_000,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned ADDR_W     = 4
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   fifo_cnt,
   output logic              overflow,
   output logic [7:0]        pi_data,
   output logic              pi_flag,
   output logic              tx_busy
);

   localparam int unsigned     BAUD_CNT   = CLK_FREQ / UART_BPS;
   localparam int unsigned     FRAME_CYC  = 10 * BAUD_CNT + 4;
   localparam logic [23:0]     FRAME_LAST = 24'(FRAME_CYC - 2);
   localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(FIFO_DEPTH);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   state_t              state_q;
   logic [7:0]          mem_q [FIFO_DEPTH];
   logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   logic                ovf_q;
   logic [7:0]          pi_data_q;
   logic                pi_flag_q;
   logic                busy_q;
   logic [23:0]         frame_cnt_q;
   logic                pop, push;

   assign full     = (cnt_q == DEPTH_C);
   assign empty    = (cnt_q == '0);
   assign fifo_cnt = cnt_q;
   assign overflow = ovf_q;
   assign pi_data  = pi_data_q;
   assign pi_flag  = pi_flag_q;
   assign tx_busy  = busy_q;

   // A pop frees a slot in the same edge, so a full FIFO can still accept a write then.
   always_comb begin
      pop   = (state_q == IDLE) && !empty;
      push  = wr_en && (!full || pop);
      cnt_d = cnt_q;
      if (push && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (pop && !push)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (push)
         mem_q[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)
            rd_ptr_q <= rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
         ovf_q <= wr_en && !push;
      end
   end

   // WAIT lasts FRAME_CYC-1 cycles, so back-to-back flags land exactly FRAME_CYC apart.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= IDLE;
         pi_data_q   <= 8'h00;
         pi_flag_q   <= 1'b0;
         busy_q      <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pop) begin
                  pi_data_q   <= mem_q[rd_ptr_q];
                  pi_flag_q   <= 1'b1;
                  busy_q      <= 1'b1;
                  frame_cnt_q <= '0;
                  state_q     <= WAIT;
               end
            end
            WAIT: begin
               pi_flag_q   <= 1'b0;
               frame_cnt_q <= frame_cnt_q + 24'd1;
               if (frame_cnt_q == FRAME_LAST) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: a queue/timing model checked every cycle, plus literal pins.
module tb_uart_tx_feeder;

   localparam int CLK_FREQ  = 50_000_000;
   localparam int UART_BPS  = 5_000_000;
   localparam int FRAME_CYC = 10 * (CLK_FREQ / UART_BPS) + 4;
   localparam int DEPTH     = 16;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n;
   logic [7:0] wr_data;
   logic       wr_en;
   logic       full, empty, overflow, pi_flag, tx_busy;
   logic [4:0] fifo_cnt;
   logic [7:0] pi_data;

   uart_tx_feeder #(
      .UART_BPS(UART_BPS), .CLK_FREQ(CLK_FREQ), .FIFO_DEPTH(DEPTH), .ADDR_W(4)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wr_data(wr_data), .wr_en(wr_en),
      .full(full), .empty(empty), .fifo_cnt(fifo_cnt), .overflow(overflow),
      .pi_data(pi_data), .pi_flag(pi_flag), .tx_busy(tx_busy)
   );

   always #5 sys_clk = ~sys_clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int t0     = 0;
   int test_id = 0;

   // Model: the FIFO is a queue; a byte may leave once it has sat a full cycle and
   // at least FRAME_CYC cycles have passed since the previous flag.
   logic [7:0] mq[$];
   int         m_last = -1000000;
   logic       e_flag = 1'b0, e_ovf = 1'b0, e_busy = 1'b0;
   logic [7:0] e_data = 8'h00;
   int         e_cnt  = 0;

   always @(posedge sys_clk) begin : model
      int   c;
      logic mpop, macc;
      c   = cyc;
      cyc = cyc + 1;
      if (!sys_rst_n) begin
         mq.delete();
         m_last = -1000000;
         e_flag = 1'b0; e_data = 8'h00; e_ovf = 1'b0; e_busy = 1'b0;
      end else begin
         mpop = (mq.size() > 0) && ((c + 1 - m_last) >= FRAME_CYC);
         macc = wr_en && ((mq.size() < DEPTH) || mpop);
         e_flag = mpop;
         if (mpop) begin
            e_data = mq.pop_front();
            m_last = c + 1;
         end
         if (macc) mq.push_back(wr_data);
         e_ovf  = wr_en && !macc;
         e_busy = (c + 1 - m_last) <= FRAME_CYC - 2;
      end
      e_cnt = mq.size();
   end

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, got, exp);
      end
   endtask

   always @(negedge sys_clk) begin : compare
      logic       x_flag, x_ovf, x_busy;
      logic [7:0] x_data;
      int         x_cnt;
      if (!sys_rst_n) begin
         x_flag = 1'b0; x_ovf = 1'b0; x_busy = 1'b0; x_data = 8'h00; x_cnt = 0;
      end else begin
         x_flag = e_flag; x_ovf = e_ovf; x_busy = e_busy; x_data = e_data; x_cnt = e_cnt;
      end
      check("pi_flag",  pi_flag,  x_flag);
      check("pi_data",  pi_data,  x_data);
      check("overflow", overflow, x_ovf);
      check("tx_busy",  tx_busy,  x_busy);
      check("fifo_cnt", fifo_cnt, x_cnt);
      check("full",     full,     x_cnt == DEPTH);
      check("empty",    empty,    x_cnt == 0);

      // Hand-computed pins anchoring the model.
      case (test_id)
         1: begin
            if (cyc == t0 + 1) check("t1_empty_fall", empty, 1'b0);
            if (cyc == t0 + 2) begin
               check("t1_flag", pi_flag, 1'b1);
               check("t1_data", pi_data, 8'hA5);
               check("t1_cnt0", fifo_cnt, 0);
               check("t1_busy_rise", tx_busy, 1'b1);
            end
            if (cyc == t0 + 104) check("t1_busy_last", tx_busy, 1'b1);
            if (cyc == t0 + 105) begin
               check("t1_busy_fall", tx_busy, 1'b0);
               check("t1_flag_low", pi_flag, 1'b0);
            end
         end
         2: begin
            if (cyc == t0 + 2)   begin check("t2_f1", pi_flag, 1'b1); check("t2_d1", pi_data, 8'h11); end
            if (cyc == t0 + 105) begin check("t2_hold_f", pi_flag, 1'b0); check("t2_hold_d", pi_data, 8'h11); end
            if (cyc == t0 + 106) begin check("t2_f2", pi_flag, 1'b1); check("t2_d2", pi_data, 8'h22); end
            if (cyc == t0 + 210) begin check("t2_f3", pi_flag, 1'b1); check("t2_d3", pi_data, 8'h33); end
         end
         3: begin
            if (cyc == t0 + 19) begin check("t3_full", full, 1'b1); check("t3_cnt16", fifo_cnt, 16); end
            if (cyc == t0 + 20) begin check("t3_ovf", overflow, 1'b1); check("t3_cnt_keep", fifo_cnt, 16); end
            if (cyc == t0 + 21) check("t3_ovf_pulse", overflow, 1'b0);
            if (cyc == t0 + 1666) begin check("t3_last_f", pi_flag, 1'b1); check("t3_last_d", pi_data, 8'h4F); end
         end
         4: begin
            if (cyc == t0 + 105) begin check("t4_drop_ovf", overflow, 1'b1); check("t4_cnt", fifo_cnt, 16); end
            if (cyc == t0 + 106) begin
               check("t4_no_ovf", overflow, 1'b0);
               check("t4_cnt_keep", fifo_cnt, 16);
               check("t4_pop_f", pi_flag, 1'b1);
               check("t4_pop_d", pi_data, 8'h50);
            end
            if (cyc == t0 + 1770) begin check("t4_new_f", pi_flag, 1'b1); check("t4_new_d", pi_data, 8'h99); end
         end
         5: begin
            if (cyc == t0 + 4058) begin check("t5_last_f", pi_flag, 1'b1); check("t5_last_d", pi_data, 8'd39); end
         end
         6: begin
            if (cyc == t0 + 50) begin check("t6_busy", tx_busy, 1'b1); check("t6_data", pi_data, 8'h61); end
            if (!sys_rst_n) begin
               check("t6_rst_data", pi_data, 8'h00);
               check("t6_rst_busy", tx_busy, 1'b0);
               check("t6_rst_empty", empty, 1'b1);
            end
            if (cyc == t0 + 300) begin check("t6_quiet_f", pi_flag, 1'b0); check("t6_quiet_e", empty, 1'b1); end
            if (cyc == t0 + 322) begin check("t6_new_f", pi_flag, 1'b1); check("t6_new_d", pi_data, 8'h7E); end
         end
         default: ;
      endcase
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) tick();
   endtask

   task automatic put(input int t, input logic [7:0] d);
      wait_to(t);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic start(input int id);
      wait_to(cyc + 3);
      t0      = cyc;
      test_id = id;
   endtask

   initial begin
      sys_rst_n = 1'b0;
      wr_en     = 1'b0;
      wr_data   = 8'h00;
      repeat (3) tick();
      sys_rst_n = 1'b1;
      repeat (3) tick();

      start(1);
      put(t0, 8'hA5);
      wait_to(t0 + 115);

      start(2);
      put(t0, 8'h11); put(t0 + 1, 8'h22); put(t0 + 2, 8'h33);
      wait_to(t0 + 320);

      start(3);
      put(t0, 8'hEE);
      for (int i = 0; i < 17; i++) put(t0 + 3 + i, 8'(8'h40 + i));
      wait_to(t0 + 1780);

      start(4);
      put(t0, 8'hEE);
      for (int i = 0; i < 16; i++) put(t0 + 3 + i, 8'(8'h50 + i));
      put(t0 + 104, 8'h98);
      put(t0 + 105, 8'h99);
      wait_to(t0 + 1880);

      start(5);
      for (int i = 0; i < 40; i++) put(t0 + 80 * i, 8'(i));
      wait_to(t0 + 4170);

      start(6);
      for (int i = 0; i < 4; i++) put(t0 + i, 8'(8'h61 + i));
      wait_to(t0 + 52);
      sys_rst_n = 1'b0;
      wait_to(t0 + 55);
      sys_rst_n = 1'b1;
      put(t0 + 320, 8'h7E);
      wait_to(t0 + 440);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
